input_debouncer: RTL and testbench

- Front-end conditioning stage placed directly upstream of the team's 2-input OR gate.
- Synchronises asynchronous raw inputs (buttons, switches) into the clock domain and filters glitches.
- Provides stable levels that drive the OR gate's a/b, plus one-cycle rise/fall event pulses and a combined "any active" flag.

---
 rtl/input_debouncer.sv | 93 +++++++++
 tb/tb_input_debouncer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Per-channel synchroniser plus run-length debounce filter. Produces clean levels,
// one-cycle rise/fall pulses, and an OR-reduced activity flag.

module input_debouncer_lane #(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // Any cycle agreeing with the clean level restarts the run; no partial credit.
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync != clean_q) begin
      if (cnt_q == CNT_MAX) begin
        clean_d = sync;
        rise_d  = sync;
        fall_d  = ~sync;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

module input_debouncer #(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_active
);
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    input_debouncer_lane #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (raw_in[g]),
      .clean_o(clean_out[g]),
      .rise_o (rise[g]),
      .fall_o (fall[g])
    );
  end

  assign any_active = |clean_out;
endmodule

// File: tb/tb_input_debouncer.sv
// Directed + randomized bench for input_debouncer against a sliding-window reference model.

module tb_input_debouncer;
  localparam int W = 2;
  localparam int K = 4;
  localparam int S = 2;

  logic         clk;
  logic         rst;
  logic [W-1:0] raw_in;
  logic [W-1:0] clean_out, rise, fall;
  logic         any_active;

  int checks   = 0;
  int failures = 0;

  // Reference model: per-edge raw samples; sync seen at edge n is raw sampled at edge n-S.
  // A channel flips when the last K synchronised values all differ from its clean level.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_clean, m_rise, m_fall;

  input_debouncer #(.WIDTH(W), .STABLE_CYCLES(K), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .clean_out (clean_out),
    .rise      (rise),
    .fall      (fall),
    .any_active(any_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (S + K) hist.push_back('0);
    m_clean = '0;
    m_rise  = '0;
    m_fall  = '0;
  endtask

  task automatic model_edge(input logic r, input logic [W-1:0] rw);
    int sz;
    logic all_diff;
    if (r) begin
      model_reset();
    end else begin
      sz = hist.size();
      for (int ch = 0; ch < W; ch++) begin
        all_diff = 1'b1;
        for (int k = 0; k < K; k++)
          if (hist[sz-S-k][ch] == m_clean[ch]) all_diff = 1'b0;
        m_rise[ch] = all_diff & ~m_clean[ch];
        m_fall[ch] = all_diff &  m_clean[ch];
        if (all_diff) m_clean[ch] = ~m_clean[ch];
      end
      hist.push_back(rw);
      if (hist.size() > 64) void'(hist.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(rst, raw_in);
    #1;
    chk("clean_out", 32'(clean_out), 32'(m_clean));
    chk("rise", 32'(rise), 32'(m_rise));
    chk("fall", 32'(fall), 32'(m_fall));
    chk("any_active", 32'(any_active), 32'(|m_clean));
    chk("rise_fall_excl", 32'(rise & fall), 32'd0);
  endtask

  initial begin
    int nr, re, hold;
    logic seen;
    model_reset();

    // Reset with inputs high: everything stays zero.
    rst = 1'b1; raw_in = 2'b11;
    repeat (2) begin
      step();
      chk("rst_clean", 32'(clean_out), 32'd0);
      chk("rst_any", 32'(any_active), 32'd0);
    end
    rst = 1'b0; raw_in = 2'b00;
    repeat (3) step();

    // Clean press on channel 0: flips on edge S+K.
    raw_in = 2'b01;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 5) chk("press_e5_clean", 32'(clean_out), 32'd0);
      if (e == 6) begin
        chk("press_e6_clean", 32'(clean_out), 32'd1);
        chk("press_e6_rise", 32'(rise), 32'd1);
        chk("press_e6_any", 32'(any_active), 32'd1);
      end
      if (e == 7) chk("press_e7_rise", 32'(rise), 32'd0);
    end

    // Glitch on channel 1 for K-1 cycles is rejected.
    seen = 1'b0;
    raw_in = 2'b11;
    for (int e = 1; e <= 12; e++) begin
      if (e == 4) raw_in = 2'b01;
      step();
      if (rise[1] || fall[1]) seen = 1'b1;
    end
    chk("glitch_pulse", 32'(seen), 32'd0);
    chk("glitch_clean", 32'(clean_out), 32'd1);

    // Bounce on channel 0 yields exactly one rise, 6 edges after stable 1.
    raw_in = 2'b00;
    repeat (8) step();
    nr = 0; re = 0;
    for (int e = 1; e <= 16; e++) begin
      raw_in[0] = (e >= 5) ? 1'b1 : ((e % 2) == 1);
      step();
      if (rise[0]) begin nr++; re = e; end
    end
    chk("bounce_count", 32'(nr), 32'd1);
    chk("bounce_edge", 32'(re), 32'd10);

    // Simultaneous release of both channels.
    raw_in = 2'b11;
    repeat (8) step();
    chk("both_high", 32'(clean_out), 32'd3);
    raw_in = 2'b00;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 6) begin
        chk("rel_fall", 32'(fall), 32'd3);
        chk("rel_clean", 32'(clean_out), 32'd0);
        chk("rel_any", 32'(any_active), 32'd0);
      end
      if (e == 7) chk("rel_fall_end", 32'(fall), 32'd0);
    end

    // Reset on edge 4 discards the pending count.
    raw_in = 2'b01;
    for (int e = 1; e <= 10; e++) begin
      rst = (e == 4);
      step();
      if (e == 4) chk("midrst_e4", 32'(clean_out), 32'd0);
      if (e == 9) chk("midrst_e9", 32'(clean_out), 32'd0);
      if (e == 10) chk("midrst_e10", 32'(clean_out), 32'd1);
    end
    rst = 1'b0;

    // Randomized held patterns with occasional resets.
    hold = 0;
    for (int c = 0; c < 2000; c++) begin
      if (hold == 0) begin
        raw_in = W'($urandom);
        hold = $urandom_range(1, 8);
      end
      hold--;
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
